// File: rtl/cross_clock_enable_sequencer.sv
// Turns a synchronized enable level into a start/stop transaction with done/timeout tracking and a 4-phase ack level.
// Optional completed-transaction counter: define CROSS_CLOCK_ENABLE_SEQ_STATS_EN.
module cross_clock_enable_sequencer #(
    parameter int          TIMEOUT_WIDTH = 16,
    parameter int unsigned TIMEOUT       = 16'hFFFF
) (
    input  logic        out_clk,
    input  logic        rst,
    input  logic        in_en_sync,
    input  logic        done,
    output logic        start,
    output logic        stop,
    output logic        active,
    output logic        ack,
    output logic        error,
    output logic [15:0] xfer_count
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        ACK
    } state_t;

    localparam bit                       TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic                     enPrev_q;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic                     start_q, stop_q, active_q, ack_q, error_q;
    logic                     stop_d, error_d;
    logic                     rise;

    assign rise = in_en_sync & ~enPrev_q;

    // Outputs are registered from the next state, so start/ack line up with the state they announce.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        error_d = error_q;
        stop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = START;
                    error_d = 1'b0;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
                if (done) begin
                    state_d = ACK;
                end else if (!in_en_sync) begin
                    stop_d  = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT_EN && (timer_q == TIMEOUT_LAST)) begin
                    error_d = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!in_en_sync) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // en_prev resets high so an enable already asserted out of reset never launches a transaction.
    always_ff @(posedge out_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            enPrev_q <= 1'b1;
            timer_q  <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            active_q <= 1'b0;
            ack_q    <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            enPrev_q <= in_en_sync;
            timer_q  <= timer_d;
            start_q  <= (state_d == START);
            stop_q   <= stop_d;
            active_q <= (state_d == START) || (state_d == WAIT_DONE);
            ack_q    <= (state_d == ACK);
            error_q  <= error_d;
        end
    end

    assign start  = start_q;
    assign stop   = stop_q;
    assign active = active_q;
    assign ack    = ack_q;
    assign error  = error_q;

`ifdef CROSS_CLOCK_ENABLE_SEQ_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge out_clk) begin
        if (rst) begin
            count_q <= '0;
        end else if ((state_q == WAIT_DONE) && done) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign xfer_count = count_q;
`else
    assign xfer_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cross_clock_enable_sequencer.sv
// Scoreboard bench for cross_clock_enable_sequencer: expected output vectors are queued per driven cycle
// and compared against the vectors captured after each clock edge.
module tb_cross_clock_enable_sequencer;

    // Output vector layout: {start, stop, active, ack, error}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_START = 5'b10100;
    localparam logic [4:0] O_WAIT  = 5'b00100;
    localparam logic [4:0] O_ACK   = 5'b00010;
    localparam logic [4:0] O_STOP  = 5'b01000;
    localparam logic [4:0] O_ERR   = 5'b00001;

`ifdef CROSS_CLOCK_ENABLE_SEQ_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        out_clk = 1'b0;
    logic        rst;
    logic        in_en_sync;
    logic        done;
    logic        start, stop, active, ack, error;
    logic [15:0] xfer_count;

    logic [20:0] expQ[$];
    logic [20:0] obsQ[$];
    logic [15:0] expCnt = 16'd0;
    int          totalCount = 0;
    int          passCount = 0;

    cross_clock_enable_sequencer #(
        .TIMEOUT_WIDTH(16),
        .TIMEOUT      (8)
    ) dut (
        .out_clk   (out_clk),
        .rst       (rst),
        .in_en_sync(in_en_sync),
        .done      (done),
        .start     (start),
        .stop      (stop),
        .active    (active),
        .ack       (ack),
        .error     (error),
        .xfer_count(xfer_count)
    );

    always #5 out_clk = ~out_clk;

    // Drives one cycle of inputs, queues the outputs expected after the edge, and captures the real ones.
    task automatic applyStimulus(input logic en, input logic dn, input bit bump, input logic [4:0] expOut);
        if (rst) expCnt = 16'd0;
        else if (bump && STATS_EN) expCnt = expCnt + 16'd1;
        in_en_sync = en;
        done       = dn;
        expQ.push_back({expOut, expCnt});
        @(posedge out_clk);
        #1;
        obsQ.push_back({start, stop, active, ack, error, xfer_count});
    endtask

    task automatic test_reset();
        logic [20:0] e, o;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, O_IDLE);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, O_IDLE);
        for (int i = 0; expQ.size() > 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            totalCount++;
            if (o !== e) $display("[TB] FAIL reset step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, o[20:16], o[15:0], e[20:16], e[15:0]);
            else passCount++;
        end
    endtask

    task automatic test_handshake();
        logic [20:0] e, o;
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        applyStimulus(1'b0, 1'b1, 1'b0, O_IDLE);
        applyStimulus(1'b1, 1'b0, 1'b0, O_START);
        applyStimulus(1'b1, 1'b1, 1'b0, O_WAIT);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, O_WAIT);
        applyStimulus(1'b1, 1'b1, 1'b1, O_ACK);
        applyStimulus(1'b1, 1'b0, 1'b0, O_ACK);
        applyStimulus(1'b1, 1'b0, 1'b0, O_ACK);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        for (int i = 0; expQ.size() > 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            totalCount++;
            if (o !== e) $display("[TB] FAIL handshake step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, o[20:16], o[15:0], e[20:16], e[15:0]);
            else passCount++;
        end
    endtask

    task automatic test_timeout();
        logic [20:0] e, o;
        applyStimulus(1'b1, 1'b0, 1'b0, O_START);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, O_WAIT);
        applyStimulus(1'b1, 1'b0, 1'b0, O_ACK | O_ERR);
        applyStimulus(1'b1, 1'b0, 1'b0, O_ACK | O_ERR);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE | O_ERR);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE | O_ERR);
        applyStimulus(1'b1, 1'b0, 1'b0, O_START);
        applyStimulus(1'b1, 1'b0, 1'b0, O_WAIT);
        applyStimulus(1'b1, 1'b1, 1'b1, O_ACK);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        for (int i = 0; expQ.size() > 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            totalCount++;
            if (o !== e) $display("[TB] FAIL timeout step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, o[20:16], o[15:0], e[20:16], e[15:0]);
            else passCount++;
        end
    endtask

    task automatic test_abort();
        logic [20:0] e, o;
        applyStimulus(1'b1, 1'b0, 1'b0, O_START);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, O_WAIT);
        applyStimulus(1'b0, 1'b0, 1'b0, O_STOP);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        applyStimulus(1'b0, 1'b1, 1'b0, O_IDLE);
        for (int i = 0; expQ.size() > 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            totalCount++;
            if (o !== e) $display("[TB] FAIL abort step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, o[20:16], o[15:0], e[20:16], e[15:0]);
            else passCount++;
        end
    endtask

    task automatic test_boundaries();
        logic [20:0] e, o;
        applyStimulus(1'b1, 1'b0, 1'b0, O_START);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, O_WAIT);
        applyStimulus(1'b1, 1'b1, 1'b1, O_ACK);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        applyStimulus(1'b1, 1'b0, 1'b0, O_START);
        applyStimulus(1'b1, 1'b0, 1'b0, O_WAIT);
        applyStimulus(1'b0, 1'b1, 1'b1, O_ACK);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        for (int i = 0; expQ.size() > 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            totalCount++;
            if (o !== e) $display("[TB] FAIL boundary step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, o[20:16], o[15:0], e[20:16], e[15:0]);
            else passCount++;
        end
    endtask

    task automatic test_mid_reset();
        logic [20:0] e, o;
        applyStimulus(1'b1, 1'b0, 1'b0, O_START);
        applyStimulus(1'b1, 1'b0, 1'b0, O_WAIT);
        applyStimulus(1'b1, 1'b0, 1'b0, O_WAIT);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, O_IDLE);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, O_IDLE);
        applyStimulus(1'b1, 1'b1, 1'b0, O_IDLE);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        applyStimulus(1'b1, 1'b0, 1'b0, O_START);
        applyStimulus(1'b1, 1'b0, 1'b0, O_WAIT);
        applyStimulus(1'b1, 1'b1, 1'b1, O_ACK);
        applyStimulus(1'b0, 1'b0, 1'b0, O_IDLE);
        for (int i = 0; expQ.size() > 0; i++) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            totalCount++;
            if (o !== e) $display("[TB] FAIL midreset step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d", i, o[20:16], o[15:0], e[20:16], e[15:0]);
            else passCount++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_en_sync = 1'b0;
        done       = 1'b0;
        test_reset();
        test_handshake();
        test_timeout();
        test_abort();
        test_boundaries();
        test_mid_reset();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
